// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared response codes and FSM encodings for the AXI4-Lite slave
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_USER = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_USER = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

endpackage

// File: rtl/axi4_lite_ack_timer.sv
// rtl/axi4_lite_ack_timer.sv - saturating wait counter flagging a missing user acknowledge
module axi4_lite_ack_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires during the TIMEOUT-th waiting cycle so the FSM leaves right after it.
    assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/axi4_lite_slave.sv
// rtl/axi4_lite_slave.sv - AXI4-Lite slave bridging to a single-cycle user register interface
module axi4_lite_slave
    import axi4_lite_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [AW-1:0]   AXI_AWADDR,
    input  logic            AXI_AWVALID,
    output logic            AXI_AWREADY,
    input  logic [DW-1:0]   AXI_WDATA,
    input  logic [DW/8-1:0] AXI_WSTRB,
    input  logic            AXI_WVALID,
    output logic            AXI_WREADY,
    output logic [1:0]      AXI_BRESP,
    output logic            AXI_BVALID,
    input  logic            AXI_BREADY,
    input  logic [AW-1:0]   AXI_ARADDR,
    input  logic            AXI_ARVALID,
    output logic            AXI_ARREADY,
    output logic [DW-1:0]   AXI_RDATA,
    output logic [1:0]      AXI_RRESP,
    output logic            AXI_RVALID,
    input  logic            AXI_RREADY,
    output logic [AW-1:0]   ASCI_WADDR,
    output logic [DW-1:0]   ASCI_WDATA,
    output logic [DW/8-1:0] ASCI_WSTRB,
    output logic            ASCI_WRITE,
    input  logic            ASCI_WACK,
    input  logic [1:0]      ASCI_WRESP,
    output logic [AW-1:0]   ASCI_RADDR,
    output logic            ASCI_READ,
    input  logic            ASCI_RACK,
    input  logic [DW-1:0]   ASCI_RDATA,
    input  logic [1:0]      ASCI_RRESP
);

    wr_state_e       wr_state_q, wr_state_d;
    logic            awready_q, awready_d, wready_q, wready_d;
    logic            aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW/8-1:0] wstrb_q, wstrb_d;
    logic            wr_pulse_q, wr_pulse_d, bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            aw_hs, w_hs, aw_have, w_have, wr_expired;

    rd_state_e       rd_state_q, rd_state_d;
    logic            arready_q, arready_d, rd_pulse_q, rd_pulse_d, rvalid_q, rvalid_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;
    logic            ar_hs, rd_expired;

    assign aw_hs   = AXI_AWVALID && awready_q;
    assign w_hs    = AXI_WVALID && wready_q;
    assign aw_have = aw_got_q || aw_hs;
    assign w_have  = w_got_q || w_hs;
    assign ar_hs   = AXI_ARVALID && arready_q;

    axi4_lite_ack_timer #(.TIMEOUT(TIMEOUT)) u_wr_timer (
        .clk       (clk),
        .resetn    (resetn),
        .clr_i     (wr_state_q != W_USER),
        .en_i      (wr_state_q == W_USER),
        .expired_o (wr_expired)
    );

    axi4_lite_ack_timer #(.TIMEOUT(TIMEOUT)) u_rd_timer (
        .clk       (clk),
        .resetn    (resetn),
        .clr_i     (rd_state_q != R_USER),
        .en_i      (rd_state_q == R_USER),
        .expired_o (rd_expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            W_IDLE:  if (aw_have && w_have) wr_state_d = W_USER;
            W_USER:  if (ASCI_WACK || wr_expired) wr_state_d = W_RESP;
            W_RESP:  if (AXI_BREADY) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    // READY is derived from the capture flags so it also rises on the first edge out of reset.
    always_comb begin
        awready_d  = awready_q;
        wready_d   = wready_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wr_pulse_d = 1'b0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) waddr_d = AXI_AWADDR;
                if (w_hs) begin
                    wdata_d = AXI_WDATA;
                    wstrb_d = AXI_WSTRB;
                end
                aw_got_d  = aw_have;
                w_got_d   = w_have;
                awready_d = !aw_have;
                wready_d  = !w_have;
                if (aw_have && w_have) begin
                    aw_got_d   = 1'b0;
                    w_got_d    = 1'b0;
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                    wr_pulse_d = 1'b1;
                end
            end
            W_USER: begin
                if (ASCI_WACK) begin
                    bresp_d  = ASCI_WRESP;
                    bvalid_d = 1'b1;
                end else if (wr_expired) begin
                    bresp_d  = RESP_SLVERR;
                    bvalid_d = 1'b1;
                end
            end
            W_RESP: begin
                if (AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (ar_hs) rd_state_d = R_USER;
            R_USER:  if (ASCI_RACK || rd_expired) rd_state_d = R_RESP;
            R_RESP:  if (AXI_RREADY) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready_d  = arready_q;
        raddr_d    = raddr_q;
        rd_pulse_d = 1'b0;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    raddr_d    = AXI_ARADDR;
                    arready_d  = 1'b0;
                    rd_pulse_d = 1'b1;
                end
            end
            R_USER: begin
                if (ASCI_RACK) begin
                    rdata_d  = ASCI_RDATA;
                    rresp_d  = ASCI_RRESP;
                    rvalid_d = 1'b1;
                end else if (rd_expired) begin
                    rdata_d  = '0;
                    rresp_d  = RESP_SLVERR;
                    rvalid_d = 1'b1;
                end
            end
            R_RESP: begin
                if (AXI_RREADY) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wr_pulse_q <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            arready_q  <= 1'b0;
            raddr_q    <= '0;
            rd_pulse_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wr_pulse_q <= wr_pulse_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            raddr_q    <= raddr_d;
            rd_pulse_q <= rd_pulse_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign AXI_AWREADY = awready_q;
    assign AXI_WREADY  = wready_q;
    assign AXI_BVALID  = bvalid_q;
    assign AXI_BRESP   = bresp_q;
    assign AXI_ARREADY = arready_q;
    assign AXI_RVALID  = rvalid_q;
    assign AXI_RDATA   = rdata_q;
    assign AXI_RRESP   = rresp_q;
    assign ASCI_WADDR  = waddr_q;
    assign ASCI_WDATA  = wdata_q;
    assign ASCI_WSTRB  = wstrb_q;
    assign ASCI_WRITE  = wr_pulse_q;
    assign ASCI_RADDR  = raddr_q;
    assign ASCI_READ   = rd_pulse_q;

endmodule

// File: doc/axi4_lite_slave.md
Name: axi4_lite_slave

Overview:
- Fully functional AXI4-Lite slave: the responder end of our AXI4-Lite master.
- Accepts AXI4-Lite reads and writes and converts each into a single-cycle request on a simple user-side register interface (ASCI).
- The user logic acknowledges each request with data and a response code.
- Sits in front of user register banks and peripherals. Independent read and write FSMs; one outstanding transaction per direction.

Parameters:
- DW, 32, data width; must be a multiple of 8.
- AW, 32, address width.
- TIMEOUT, 256, max cycles to wait for a user ack before answering SLVERR; 0 disables the timeout.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- AXI_AWADDR in AW; AXI_AWVALID in 1; AXI_AWREADY out 1: write-address channel.
- AXI_WDATA in DW; AXI_WSTRB in DW/8; AXI_WVALID in 1; AXI_WREADY out 1: write-data channel.
- AXI_BRESP out 2; AXI_BVALID out 1; AXI_BREADY in 1: write-response channel.
- AXI_ARADDR in AW; AXI_ARVALID in 1; AXI_ARREADY out 1: read-address channel.
- AXI_RDATA out DW; AXI_RRESP out 2; AXI_RVALID out 1; AXI_RREADY in 1: read-data channel.
- ASCI_WADDR out AW; ASCI_WDATA out DW; ASCI_WSTRB out DW/8: captured write request.
- ASCI_WRITE out 1: one-cycle write request pulse.
- ASCI_WACK in 1; ASCI_WRESP in 2: user write acknowledge and response.
- ASCI_RADDR out AW: captured read address.
- ASCI_READ out 1: one-cycle read request pulse.
- ASCI_RACK in 1; ASCI_RDATA in DW; ASCI_RRESP in 2: user read acknowledge, data and response.

Behaviour:
- Reset: all VALID/READY outputs, ASCI_WRITE and ASCI_READ are 0; both FSMs go to IDLE; address, data and response registers are 0. Reset applies mid-transaction too: any in-flight request is dropped and no B/R response is issued.
- All outputs are registered. AWREADY, WREADY and ARREADY rise on the first clk edge after resetn deasserts.
- Write FSM, state W_IDLE:
  - AWREADY=1 until the AW handshake, then 0; address latched.
  - WREADY=1 until the W handshake, then 0; data and strobe latched.
  - AW and W may handshake in any order or in the same cycle.
  - When both have been captured (including the cycle in which the last one completes), go to W_USER.
- W_USER:
  - ASCI_WRITE is high only in the first cycle of the state.
  - Stay until ASCI_WACK=1; an ack in the same cycle as the pulse is legal. Latch ASCI_WRESP into BRESP, set BVALID=1, go to W_RESP.
  - Timer counts cycles in W_USER. If it reaches TIMEOUT with no ack, set BRESP=SLVERR and go to W_RESP.
- W_RESP: hold BVALID and BRESP until BREADY. On the handshake, BVALID=0, AWREADY=WREADY=1, return to W_IDLE.
- Minimum write latency: AW/W handshake in cycle N, ASCI_WRITE in N+1, ack in N+1, BVALID in N+2.
- Read FSM, state R_IDLE: ARREADY=1. On the AR handshake, latch the address, ARREADY=0, go to R_USER.
- R_USER:
  - ASCI_READ is high only in the first cycle of the state.
  - On ASCI_RACK, latch RDATA and RRESP, set RVALID=1, go to R_RESP.
  - On timeout: RDATA=0, RRESP=SLVERR, go to R_RESP.
- R_RESP: hold RVALID, RDATA and RRESP until RREADY. On the handshake, RVALID=0, ARREADY=1, return to R_IDLE.
- An ack outside W_USER/R_USER (for example a late ack after a timeout) is ignored.
- Read and write FSMs are fully independent; simultaneous read and write requests are legal.
- WSTRB is passed through untouched; the user applies byte enables.
- Timer: width clog2(TIMEOUT+1); cleared on entering a USER state; never wraps.

Decomposition:
- Package axi4_lite_pkg:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Write and read FSM state encodings (IDLE/USER/RESP).
- Sub-module axi4_lite_ack_timer: counter with clear and enable inputs and an expired output, parameterized by TIMEOUT. Instantiated once per FSM.

Test Plan:
- Write with AW and W in the same cycle: addr 0x10, data 0xDEADBEEF, WSTRB 0xF, ack on the pulse cycle with WRESP=0 -> ASCI_WADDR=0x10, ASCI_WDATA=0xDEADBEEF, exactly one ASCI_WRITE pulse, BVALID two cycles after the handshake, BRESP=OKAY.
- W three cycles before AW, then BREADY held low for 5 cycles -> WREADY drops after the W handshake, AWREADY stays high until AW; BVALID/BRESP held stable for 5 cycles; AWREADY and WREADY reassert one cycle after the B handshake.
- Read addr 0x24, ack two cycles after the pulse with RDATA 0x12345678 and RRESP=DECERR -> RVALID with RDATA 0x12345678, RRESP=2'b11; ARREADY low until the R handshake completes.
- TIMEOUT=8, no user ack on a read -> RVALID after 8 cycles in R_USER with RRESP=SLVERR and RDATA=0; a late RACK is ignored and no second RVALID occurs.
- Concurrent write 0x0 and read 0x4 in the same cycle with staggered acks -> both complete independently with correct BRESP/RDATA; no cross-talk between the ASCI strobes.
- Assert resetn low while in W_USER -> all outputs 0 asynchronously, no BVALID afterwards; AWREADY, WREADY and ARREADY return to 1 one cycle after release.
